// File: rtl/seg_pkg.sv
// Shared types and helpers for the 7-segment scanner.
package seg_pkg;

   localparam int NDIG = 8;

   typedef logic [7:0] seg_t;
   typedef seg_t seg_bank_t [NDIG];

   // Digit index to one-hot digit enable.
   function automatic seg_t dig_onehot(input logic [2:0] idx);
      return seg_t'(8'h01 << idx);
   endfunction

endpackage

// File: rtl/slot_timer.sv
// Digit-slot timer: a position counter that runs 0..DIV-1 inside each digit
// slot. It reports the last clock of the slot and whether the next clock
// falls in the show phase, so that the scanner can register its outputs in
// step with the counter.
module slot_timer #(
   parameter int DIV   = 1000,
   parameter int BLANK = 16,
   parameter int CW    = (DIV > 1) ? $clog2(DIV) : 1
) (
   input  logic clk,
   input  logic rst_n,
   output logic slot_end,
   output logic show_nxt
);

   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;

   assign slot_end = (cnt == LAST);
   assign cnt_nxt  = slot_end ? '0 : cnt + CW'(1);

   // Slot position counter; wraps on the last clock of the slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else begin
         cnt <= cnt_nxt;
      end
   end

   // With no blanking every clock of the slot shows the digit; the compare is
   // kept out of that case so it is never a constant-true unsigned compare.
   if (BLANK == 0) begin : g_no_blank
      assign show_nxt = 1'b1;
   end else begin : g_blank
      localparam logic [CW-1:0] BL = CW'(BLANK);
      assign show_nxt = (cnt_nxt >= BL);
   end

endmodule

// File: rtl/seg_scanner.sv
// Time-multiplexed 7-segment driver. Snapshots the eight segment patterns and
// the select word once per frame, then scans digits 0..7 with a blanking gap
// at the start of each digit slot. All LED outputs are registered and line up
// with the scan position of the cycle they appear in.
module seg_scanner
   import seg_pkg::*;
#(
   parameter int DIV   = 1000,
   parameter int BLANK = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] seg_a,
   input  logic [7:0] seg_b,
   input  logic [7:0] seg_c,
   input  logic [7:0] seg_d,
   input  logic [7:0] seg_e,
   input  logic [7:0] seg_f,
   input  logic [7:0] seg_g,
   input  logic [7:0] seg_h,
   input  logic [7:0] controll,
   output logic [7:0] led_seg,
   output logic [7:0] led_dig,
   output logic [7:0] led_sel,
   output logic       frame_done
);

   logic       slot_end;
   logic       show_nxt;
   logic       started;
   logic       take;
   logic [2:0] idx;
   logic [2:0] idx_nxt;
   seg_bank_t  snap;
   seg_bank_t  bank_in;
   seg_t       seg_src;

   slot_timer #(
      .DIV   (DIV),
      .BLANK (BLANK)
   ) u_slot_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .slot_end (slot_end),
      .show_nxt (show_nxt)
   );

   assign bank_in = '{seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g, seg_h};

   // Capture on the first edge after reset and on the last clock of digit 7.
   assign take    = !started || ((idx == 3'd7) && slot_end);
   assign idx_nxt = slot_end ? idx + 3'd1 : idx;

   // On a capture edge the snapshot is being loaded in the same edge, so the
   // first digit of the new frame (visible at once when BLANK is 0) must come
   // straight from the inputs.
   assign seg_src = take ? bank_in[idx_nxt] : snap[idx_nxt];

   // Digit index, first-edge flag and the per-frame snapshot bank.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx     <= '0;
         started <= 1'b0;
         snap    <= '{default: '0};
         led_sel <= '0;
      end else begin
         idx     <= idx_nxt;
         started <= 1'b1;
         if (take) begin
            snap    <= bank_in;
            led_sel <= controll;
         end
      end
   end

   // LED pin flops, loaded with the values for the next scan position.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         led_dig    <= '0;
         led_seg    <= '0;
         frame_done <= 1'b0;
      end else begin
         led_dig    <= show_nxt ? dig_onehot(idx_nxt) : '0;
         led_seg    <= show_nxt ? seg_src : '0;
         frame_done <= (idx == 3'd7) && slot_end;
      end
   end

endmodule

// File: tb/tb_seg_scanner.sv
// Bench for seg_scanner: three instances (DIV/BLANK = 8/2, 4/0, 2/1) driven
// from shared inputs. Expected outputs for each cycle are derived from the
// cycle count since reset release and a per-instance frame snapshot, pushed
// to a queue when the inputs for that edge are driven, and popped one cycle
// later against the DUT outputs.
module tb_seg_scanner;

   typedef struct packed {
      logic [7:0] dig;
      logic [7:0] seg;
      logic [7:0] sel;
      logic       fd;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic [7:0] segs [8];
   logic [7:0] controll;

   logic [7:0] dig0, seg0, sel0;
   logic [7:0] dig1, seg1, sel1;
   logic [7:0] dig2, seg2, sel2;
   logic       fd0, fd1, fd2;

   int         n_cmp;
   int         n_err;
   int         k;
   int         phase;
   int         fd_cnt;
   exp_t       q [$];
   logic [7:0] msnap [3][8];
   logic [7:0] msel  [3];

   seg_scanner #(.DIV(8), .BLANK(2)) u_dut0 (
      .clk(clk), .rst_n(rst_n),
      .seg_a(segs[0]), .seg_b(segs[1]), .seg_c(segs[2]), .seg_d(segs[3]),
      .seg_e(segs[4]), .seg_f(segs[5]), .seg_g(segs[6]), .seg_h(segs[7]),
      .controll(controll),
      .led_seg(seg0), .led_dig(dig0), .led_sel(sel0), .frame_done(fd0)
   );

   seg_scanner #(.DIV(4), .BLANK(0)) u_dut1 (
      .clk(clk), .rst_n(rst_n),
      .seg_a(segs[0]), .seg_b(segs[1]), .seg_c(segs[2]), .seg_d(segs[3]),
      .seg_e(segs[4]), .seg_f(segs[5]), .seg_g(segs[6]), .seg_h(segs[7]),
      .controll(controll),
      .led_seg(seg1), .led_dig(dig1), .led_sel(sel1), .frame_done(fd1)
   );

   seg_scanner #(.DIV(2), .BLANK(1)) u_dut2 (
      .clk(clk), .rst_n(rst_n),
      .seg_a(segs[0]), .seg_b(segs[1]), .seg_c(segs[2]), .seg_d(segs[3]),
      .seg_e(segs[4]), .seg_f(segs[5]), .seg_g(segs[6]), .seg_h(segs[7]),
      .controll(controll),
      .led_seg(seg2), .led_dig(dig2), .led_sel(sel2), .frame_done(fd2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int div_of(input int i);
      case (i)
         0:       return 8;
         1:       return 4;
         default: return 2;
      endcase
   endfunction

   function automatic int blank_of(input int i);
      case (i)
         0:       return 2;
         1:       return 0;
         default: return 1;
      endcase
   endfunction

   function automatic exp_t observed(input int i);
      exp_t o;
      case (i)
         0:       o = '{dig: dig0, seg: seg0, sel: sel0, fd: fd0};
         1:       o = '{dig: dig1, seg: seg1, sel: sel1, fd: fd1};
         default: o = '{dig: dig2, seg: seg2, sel: sel2, fd: fd2};
      endcase
      return o;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", tag, k, got, want);
      end
   endtask

   // Expected outputs for instance i in cycle n (n >= 1 after release).
   function automatic exp_t model(input int i, input int n);
      exp_t e;
      int   d   = div_of(i);
      int   idx = (n / d) % 8;
      int   cnt = n % d;
      logic show = (cnt >= blank_of(i));
      e.dig = show ? 8'(1 << idx) : 8'h00;
      e.seg = show ? msnap[i][idx] : 8'h00;
      e.sel = msel[i];
      e.fd  = (n > 0) && ((n % (8 * d)) == 0);
      return e;
   endfunction

   task automatic check_zero(input string tag);
      for (int i = 0; i < 3; i++) begin
         exp_t o = observed(i);
         check($sformatf("%s_dut%0d", tag, i), 32'(o), 32'(0));
      end
   endtask

   task automatic stim();
      if (phase == 0) begin
         if (k == 5)  segs[0] = 8'h01;
         if (k == 20) begin
            segs[7]  = 8'h3F;
            controll = 8'hC3;
         end
         if (k == 70) segs[7] = 8'h80;
      end else begin
         if (k == 10) segs[2] = 8'hFF;
      end
   endtask

   // Mirror of the capture points: cycle 0 edge and the last edge of each frame.
   task automatic snap_model();
      for (int i = 0; i < 3; i++) begin
         int f = 8 * div_of(i);
         if ((k == 0) || ((k % f) == f - 1)) begin
            for (int j = 0; j < 8; j++) msnap[i][j] = segs[j];
            msel[i] = controll;
         end
      end
   endtask

   task automatic push_next();
      for (int i = 0; i < 3; i++) q.push_back(model(i, k + 1));
   endtask

   task automatic compare_cycle();
      for (int i = 0; i < 3; i++) begin
         exp_t e;
         exp_t o = observed(i);
         if (q.size() == 0) begin
            check($sformatf("queue_empty_dut%0d", i), 32'(1), 32'(0));
         end else begin
            e = q.pop_front();
            check($sformatf("dig_dut%0d", i), 32'(o.dig), 32'(e.dig));
            check($sformatf("seg_dut%0d", i), 32'(o.seg), 32'(e.seg));
            check($sformatf("sel_dut%0d", i), 32'(o.sel), 32'(e.sel));
            check($sformatf("fd_dut%0d", i),  32'(o.fd),  32'(e.fd));
         end
         check($sformatf("onehot_dut%0d", i), 32'($countones(o.dig) <= 1), 32'(1));
      end
      if (dig1 == 8'h00) check("noblank_dig_zero", 32'(dig1), 32'(1));
      if (phase == 0) begin
         if (fd0) fd_cnt++;
         if (k == 3)   check("t1_seg_ff",      32'(seg0), 32'(8'hFF));
         if (k == 61)  check("tear_old_seg_h", 32'(seg0), 32'(8'h00));
         if (k == 61)  check("tear_old_sel",   32'(sel0), 32'(8'h5A));
         if (k == 66)  check("new_seg_a",      32'(seg0), 32'(8'h01));
         if (k == 125) check("tear_new_seg_h", 32'(seg0), 32'(8'h3F));
         if (k == 125) check("tear_new_sel",   32'(sel0), 32'(8'hC3));
         if (k == 64 || k == 128 || k == 192) check("fd_pulse", 32'(fd0), 32'(1));
      end else begin
         if (k == 2)  check("rst2_seg_a",  32'(seg0), 32'(8'h11));
         if (k == 20) check("rst2_old_c",  32'(seg0), 32'(8'h33));
         if (k == 84) check("rst2_new_c",  32'(seg0), 32'(8'hFF));
      end
   endtask

   task automatic step();
      @(negedge clk);
      k++;
      compare_cycle();
      stim();
      snap_model();
      push_next();
   endtask

   task automatic release_rst();
      @(negedge clk);
      check_zero("reset_state");
      rst_n = 1'b1;
      k = 0;
      q.delete();
      for (int i = 0; i < 3; i++) begin
         msel[i] = 8'h00;
         for (int j = 0; j < 8; j++) msnap[i][j] = 8'h00;
      end
      #1;
      check_zero("cycle0");
      stim();
      snap_model();
      push_next();
   endtask

   initial begin
      n_cmp    = 0;
      n_err    = 0;
      k        = 0;
      phase    = 0;
      fd_cnt   = 0;
      rst_n    = 1'b0;
      segs     = '{8'hFF, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h00};
      controll = 8'h5A;

      repeat (3) begin
         @(negedge clk);
         check_zero("in_reset");
      end

      release_rst();
      while (k < 229) step();
      check("fd_count_3_frames", 32'(fd_cnt), 32'(3));

      // Reset in cycle 229 (frame 3, digit 4 showing on the 8/2 instance).
      rst_n = 1'b0;
      q.delete();
      #1;
      check_zero("async_rst");
      repeat (2) begin
         @(negedge clk);
         check_zero("held_rst");
      end

      phase = 1;
      for (int j = 0; j < 8; j++) segs[j] = 8'(8'h11 * (j + 1));
      controll = 8'hA5;
      release_rst();
      while (k < 150) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
